// File: rtl/bb8051_dptr_bank_if.sv
// bb8051_dptr_bank_if: SFR bus and core datapath signals of the banked DPTR unit
`ifndef BB8051_SFR_ACT_WR_BYTE
`define BB8051_SFR_ACT_WR_BYTE 2'd1
`endif
`ifndef BB8051_SFR_ACT_WR_BIT
`define BB8051_SFR_ACT_WR_BIT 2'd2
`endif
interface bb8051_dptr_bank_if;
  logic [1:0] sfr_action;
  logic [1:0] sfr_sel;
  logic [7:0] wr_data;
  logic [2:0] bit_addr;
  logic       bit_data;
  logic       inc_req;
  logic       movx_done;
  logic [7:0] dptr_out_h;
  logic [7:0] dptr_out_l;
  logic [7:0] dps_out;
  modport master (
    output sfr_action, sfr_sel, wr_data, bit_addr, bit_data, inc_req, movx_done,
    input  dptr_out_h, dptr_out_l, dps_out
  );
  modport slave (
    input  sfr_action, sfr_sel, wr_data, bit_addr, bit_data, inc_req, movx_done,
    output dptr_out_h, dptr_out_l, dps_out
  );
endinterface

// File: rtl/bb8051_dptr_bank.sv
// bb8051_dptr_bank: banked 16-bit data pointers with DPS select, INC DPTR and MOVX auto-update/toggle
module bb8051_dptr_bank #(
  parameter int          NUM_DPTR = 2,
  parameter logic [15:0] RST_DPTR = 16'h0000
) (
  input logic              clk,
  input logic              rst,
  bb8051_dptr_bank_if.slave dptr_if
);
  localparam int SW = NUM_DPTR > 1 ? $clog2(NUM_DPTR) : 1;
  logic [15:0]   ptr_q [NUM_DPTR];
  logic [15:0]   ptr_d [NUM_DPTR];
  logic [SW-1:0] sel_q, sel_d, sel_inc;
  logic          tsl_q, tsl_d, aid_q, aid_d, dec_q, dec_d;
  logic [15:0]   cur, cur_nxt;
  logic          cur_upd, wr_byte, wr, dps_wr;
  logic [7:0]    dps_rd, old_b, new_b;
  // active pointer selected by SEL; a SEL naming no pointer reads as zero
  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_DPTR; i++) cur = (SW'(i) == sel_q) ? ptr_q[i] : cur;
  end
  assign dps_rd  = {tsl_q, aid_q, dec_q, 2'b00, 3'(sel_q)};
  assign sel_inc = SW'((32'(sel_q) + 32'd1) % NUM_DPTR);
  assign wr_byte = dptr_if.sfr_action == `BB8051_SFR_ACT_WR_BYTE;
  assign wr      = wr_byte || dptr_if.sfr_action == `BB8051_SFR_ACT_WR_BIT;
  assign dps_wr  = wr && dptr_if.sfr_sel == 2'd2;
  assign old_b   = dptr_if.sfr_sel == 2'd0 ? cur[7:0] : dptr_if.sfr_sel == 2'd1 ? cur[15:8] : dps_rd;
  assign new_b   = wr_byte ? dptr_if.wr_data
                 : (old_b & ~(8'd1 << dptr_if.bit_addr)) | (8'(dptr_if.bit_data) << dptr_if.bit_addr);
  // next value of the active pointer: SFR write beats INC DPTR beats MOVX auto-update
  always_comb begin
    cur_upd = (wr && !dptr_if.sfr_sel[1]) || dptr_if.inc_req || (dptr_if.movx_done && aid_q);
    cur_nxt = (wr && dptr_if.sfr_sel == 2'd0) ? {cur[15:8], new_b}
            : (wr && dptr_if.sfr_sel == 2'd1) ? {new_b, cur[7:0]}
            : (dptr_if.inc_req || !dec_q)     ? cur + 16'd1
            : cur - 16'd1;
    for (int i = 0; i < NUM_DPTR; i++) ptr_d[i] = (cur_upd && SW'(i) == sel_q) ? cur_nxt : ptr_q[i];
  end
  // DPS next state: a DPS write wins over the post-MOVX toggle of SEL
  always_comb begin
    tsl_d = dps_wr ? new_b[7] : tsl_q;
    aid_d = dps_wr ? new_b[6] : aid_q;
    dec_d = dps_wr ? new_b[5] : dec_q;
    sel_d = dps_wr ? (NUM_DPTR == 1 ? '0 : new_b[SW-1:0])
          : (dptr_if.movx_done && tsl_q) ? sel_inc : sel_q;
  end
  // state registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DPTR; i++) ptr_q[i] <= RST_DPTR;
      sel_q <= '0;
      tsl_q <= 1'b0;
      aid_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DPTR; i++) ptr_q[i] <= ptr_d[i];
      sel_q <= sel_d;
      tsl_q <= tsl_d;
      aid_q <= aid_d;
      dec_q <= dec_d;
    end
  end
  assign dptr_if.dptr_out_h = cur[15:8];
  assign dptr_if.dptr_out_l = cur[7:0];
  assign dptr_if.dps_out    = dps_rd;
endmodule
